// File: rtl/nor_rd_cache.sv
// Direct-mapped, one-word-per-line read cache between a CPU and a qqspi NOR controller.
// Optional hit/miss statistics are built when NOR_CACHE_STATS_EN is defined.
module nor_rd_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_valid,
  output logic [22:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 22 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [21:0]       r_wa;
  logic [31:0]       r_rdata;
  logic [LINES-1:0]  r_valid;
  logic              r_flushed;
  logic [TAG_W-1:0]  r_tag_mem  [LINES];
  logic [31:0]       r_data_mem [LINES];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_accept;
  logic              w_hit;
  logic              w_fill_done;
  logic              w_unused_addr;

  assign w_idx         = r_wa[IDX_W-1:0];
  assign w_tag         = r_wa[21:IDX_W];
  assign w_accept      = (r_state == S_IDLE) && cpu_valid && !cpu_ready;
  // A flush arriving in LOOKUP must not let a soon-to-be-invalid line hit.
  assign w_hit         = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag) && !flush;
  assign w_fill_done   = (r_state == S_FILL) && mem_ready;
  assign w_unused_addr = ^{cpu_addr[31:24], cpu_addr[1:0]};

  // NOTE: state and datapath registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: w_next = w_hit ? S_RESP : S_FILL;
      S_FILL:   if (mem_ready) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = (r_state == S_RESP);
    mem_valid = (r_state == S_FILL);
    cpu_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
    mem_addr  = {1'b0, r_wa};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wa      <= '0;
      r_rdata   <= '0;
      r_valid   <= '0;
      r_flushed <= 1'b0;
    end else begin
      if (w_accept) r_wa <= cpu_addr[23:2];

      if (r_state == S_LOOKUP && w_hit) r_rdata <= r_data_mem[w_idx];
      else if (w_fill_done)             r_rdata <= mem_rdata;

      // A flush seen at any point of a refill keeps that line invalid afterwards.
      if (r_state == S_LOOKUP)            r_flushed <= 1'b0;
      else if (r_state == S_FILL && flush) r_flushed <= 1'b1;

      if (flush)                          r_valid <= '0;
      else if (w_fill_done && !r_flushed) r_valid[w_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether
  // their contents mean anything, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag_mem[w_idx]  <= w_tag;
      r_data_mem[w_idx] <= mem_rdata;
    end
  end

`ifdef NOR_CACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_nor_rd_cache.sv
// Directed self-checking bench for nor_rd_cache (LINES=64); the bench drives the
// qqspi side itself and knows every expected value up front.
module tb_nor_rd_cache;

`ifdef NOR_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_valid;
  logic [22:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_total = 0;
  int n_bad   = 0;

  nor_rd_cache #(.LINES(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int hits, input int misses);
    check({tag, "_hit_cnt"},  hit_cnt,  STATS ? 32'(hits)   : 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, STATS ? 32'(misses) : 32'd0);
  endtask

  // One CPU read; on a refill the bench answers after `delay` mem_valid cycles.
  // flush_cyc pulses flush in that cycle after cpu_valid (1 = LOOKUP cycle).
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input int delay, input int flush_cyc, input bit exp_miss,
                         input logic [31:0] exp_rdata);
    int          cycles = 0;
    int          mem_cnt = 0;
    int          rdy_cyc = 0;
    bit          done = 1'b0;
    bit          leak = 1'b0;
    bit          unstable = 1'b0;
    bit          mv_at_resp = 1'b0;
    logic [22:0] maddr = '0;
    logic [31:0] rdata = '0;

    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    while (!done && cycles < 60) begin
      @(negedge clk);
      cycles++;
      mem_ready = 1'b0;
      flush     = (cycles == flush_cyc);
      if (cpu_ready) begin
        done       = 1'b1;
        rdata      = cpu_rdata;
        mv_at_resp = mem_valid;
        cpu_valid  = 1'b0;
      end else begin
        if (cpu_rdata != 32'd0) leak = 1'b1;
        if (mem_valid) begin
          mem_cnt++;
          if (mem_cnt == 1) maddr = mem_addr;
          else if (mem_addr !== maddr) unstable = 1'b1;
          if (mem_cnt == delay) begin
            mem_ready = 1'b1;
            mem_rdata = data;
            rdy_cyc   = cycles;
          end
        end
      end
    end
    cpu_valid = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;

    check({tag, "_completed"},   32'(done), 32'd1);
    check({tag, "_rdata"},       rdata, exp_rdata);
    check({tag, "_missed"},      32'(mem_cnt != 0), 32'(exp_miss));
    check({tag, "_rdata_idle0"}, 32'(leak), 32'd0);
    check({tag, "_mv_in_resp"},  32'(mv_at_resp), 32'd0);
    if (exp_miss) begin
      check({tag, "_mem_addr"},    32'(maddr), {9'd0, 1'b0, addr[23:2]});
      check({tag, "_addr_stable"}, 32'(unstable), 32'd0);
      check({tag, "_mv_cycles"},   32'(mem_cnt), 32'(delay));
      check({tag, "_fill_lat"},    32'(cycles - rdy_cyc), 32'd1);
    end else begin
      check({tag, "_hit_lat"},     32'(cycles), 32'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit quiet;

    resetn    = 1'b0;
    flush     = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    #1;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_cpu_rdata", cpu_rdata,      32'd0);
    check_stats("rst", 0, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Cold miss then warm hit on the same word.
    do_read("cold", 32'h2010_0040, 32'hDEAD_BEEF, 5, 0, 1'b1, 32'hDEAD_BEEF);
    check_stats("cold", 0, 1);
    do_read("warm", 32'h2010_0040, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'hDEAD_BEEF);
    check_stats("warm", 1, 1);

    // Same index (0), different tags: each evicts the previous line.
    do_read("alias_a",   32'h2000_0000, 32'h1111_1111, 3, 0, 1'b1, 32'h1111_1111);
    do_read("alias_b",   32'h2000_0100, 32'h2222_2222, 4, 0, 1'b1, 32'h2222_2222);
    do_read("alias_c",   32'h2000_0000, 32'h3333_3333, 2, 0, 1'b1, 32'h3333_3333);
    do_read("alias_hit", 32'h2000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h3333_3333);
    do_read("other_idx", 32'h2010_0040, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'hDEAD_BEEF);
    check_stats("alias", 3, 4);

    // Flush during FILL: data returned, line stays invalid.
    do_read("fl_fill",   32'h2000_0200, 32'h4444_4444, 4, 3, 1'b1, 32'h4444_4444);
    do_read("fl_reread", 32'h2000_0200, 32'h5555_5555, 3, 0, 1'b1, 32'h5555_5555);
    do_read("fl_hit",    32'h2000_0200, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h5555_5555);

    // Flush in LOOKUP forces a miss on a valid line.
    do_read("fl_lookup",     32'h2000_0200, 32'h8888_8888, 2, 1, 1'b1, 32'h8888_8888);
    do_read("fl_lookup_hit", 32'h2000_0200, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h8888_8888);
    do_read("cold_after_fl", 32'h2010_0040, 32'h6666_6666, 3, 0, 1'b1, 32'h6666_6666);
    check_stats("flush", 5, 8);

    // Reset while a refill is outstanding, then a stray mem_ready.
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = 32'h2000_0400;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
    end
    check("rst_fill_started", 32'(seen), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_mem_addr",  32'(mem_addr),  32'd0);
    check("midrst_cpu_rdata", cpu_rdata,      32'd0);
    check_stats("midrst", 0, 0);
    cpu_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ready = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (cpu_ready || mem_valid || cpu_rdata != 32'd0) quiet = 1'b0;
      @(negedge clk);
    end
    check("stray_mem_ready_ignored", 32'(quiet), 32'd1);

    do_read("post_rst", 32'h2010_0040, 32'h7777_7777, 2, 0, 1'b1, 32'h7777_7777);
    check_stats("post_rst", 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
